// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared constants for the T-rex obstacle path: game-state encodings, obstacle
// type codes, per-type box geometry and the obstacle LFSR feedback mask.
// No ports; imported by the interface, the top and the LFSR sub-module.
// -----------------------------------------------------------------------------
package dino_pkg;

  // Encoding 3 is not produced by the game FSM; consumers treat it like OVER.
  typedef enum logic [1:0] {
    GS_IDLE     = 2'd0,
    GS_RUN      = 2'd1,
    GS_OVER     = 2'd2,
    GS_OVER_ALT = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    OBS_CACTUS_S = 2'd0,
    OBS_CACTUS_L = 2'd1,
    OBS_BIRD_LO  = 2'd2,
    OBS_BIRD_HI  = 2'd3
  } obs_type_e;

  localparam int OBS_X_W   = 12;  // slot x, signed
  localparam int COORD_W   = 13;  // hit-test compare width, signed
  localparam int GAP_W     = 8;   // spawn gap counter

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Box width per type.
  function automatic logic signed [COORD_W-1:0] obs_w(input logic [1:0] t);
    case (obs_type_e'(t))
      OBS_CACTUS_S: return 13'sd17;
      OBS_CACTUS_L: return 13'sd25;
      default:      return 13'sd46;
    endcase
  endfunction

  // Box height per type.
  function automatic logic signed [COORD_W-1:0] obs_h(input logic [1:0] t);
    case (obs_type_e'(t))
      OBS_CACTUS_S: return 13'sd35;
      OBS_CACTUS_L: return 13'sd50;
      default:      return 13'sd40;
    endcase
  endfunction

  // Distance of the box top above the horizon.
  function automatic logic signed [COORD_W-1:0] obs_top_off(input logic [1:0] t);
    case (obs_type_e'(t))
      OBS_CACTUS_S: return 13'sd35;
      OBS_CACTUS_L: return 13'sd50;
      OBS_BIRD_LO:  return 13'sd40;
      default:      return 13'sd90;
    endcase
  endfunction

endpackage

// File: rtl/obstacle_delegate_if.sv
// -----------------------------------------------------------------------------
// obstacle_delegate_if
// Bundles the game-side signals of the obstacle block.
//   master : game/scan side - drives ObstacleClock, gameState, vgaX, vgaY;
//            receives inGrey and the per-slot boxes.
//   slave  : obstacle_delegate itself.
// -----------------------------------------------------------------------------
interface obstacle_delegate_if;

  logic                ObstacleClock;  // scroll divider level, sync to clk
  logic [1:0]          gameState;      // dino_pkg::game_state_e encoding
  logic [31:0]         vgaX;           // current scan pixel
  logic [31:0]         vgaY;
  logic                inGrey;         // scan pixel inside an active box
  logic [1:0]          obsActive;      // valid bit per slot
  logic signed [11:0]  obsX0;          // left edge, slot 0
  logic signed [11:0]  obsX1;          // left edge, slot 1
  logic [1:0]          obsType0;
  logic [1:0]          obsType1;

  modport master (
    output ObstacleClock, gameState, vgaX, vgaY,
    input  inGrey, obsActive, obsX0, obsX1, obsType0, obsType1
  );

  modport slave (
    input  ObstacleClock, gameState, vgaX, vgaY,
    output inGrey, obsActive, obsX0, obsX1, obsType0, obsType1
  );

endinterface

// File: rtl/obstacle_delegate_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR, shifting right every clk with feedback mask
// dino_pkg::LFSR_MASK. Loads seed on reset; a nonzero seed never reaches 0.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   seed : reset value (must be nonzero)
//   q    : current register value
// -----------------------------------------------------------------------------
module lfsr16
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_MASK : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_delegate.sv
// -----------------------------------------------------------------------------
// obstacle_delegate
// Spawns, scrolls and retires the two ground-obstacle slots of the T-rex game
// and produces the per-pixel inGrey mask for the colour select.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : obstacle_delegate_if.slave
//              in : ObstacleClock (scroll level), gameState, vgaX, vgaY
//              out: inGrey (combinational), obsActive, obsX0/1, obsType0/1
//
// gameState handling
//   state    | meaning
//   IDLE (0) | slots and gap counter frozen, ticks ignored
//   RUN  (1) | slots scroll/retire/spawn on each tick
//   OVER (2) | frozen like IDLE
//   3        | treated as OVER
// The first clk seen in RUN with the registered previous state not RUN clears
// both slots and reloads the gap counter; a tick on that cycle is dropped.
// -----------------------------------------------------------------------------
module obstacle_delegate
  import dino_pkg::*;
#(
  parameter int          ScreenW = 640,
  parameter int          GroundY = 360,
  parameter int          STEP    = 4,
  parameter int          MIN_GAP = 40,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  obstacle_delegate_if.slave  bus
);

  localparam logic signed [OBS_X_W-1:0] SPAWN_X  = OBS_X_W'(ScreenW);
  localparam logic signed [COORD_W-1:0] STEP_S   = COORD_W'(STEP);
  localparam logic signed [COORD_W-1:0] GROUND_S = COORD_W'(GroundY);
  localparam logic [GAP_W-1:0]          GAP_INIT = GAP_W'(MIN_GAP);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                       oc_q, oc_d;
  game_state_e                prev_gs_q, prev_gs_d;
  logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
  logic [1:0]                 active_q, active_d;
  logic signed [OBS_X_W-1:0]  x_q [2];
  logic signed [OBS_X_W-1:0]  x_d [2];
  logic [1:0]                 type_q [2];
  logic [1:0]                 type_d [2];

  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Only the low six bits feed type and gap selection.
  assign unused_lfsr = ^lfsr_q[15:6];

  // ---------------------------------------------------------------------------
  // Tick detect and RUN entry
  // ---------------------------------------------------------------------------
  logic run, enter_run, tick;

  assign run       = (game_state_e'(bus.gameState) == GS_RUN);
  assign enter_run = run && (prev_gs_q != GS_RUN);
  assign tick      = bus.ObstacleClock && !oc_q;

  // ---------------------------------------------------------------------------
  // Slot update
  // ---------------------------------------------------------------------------
  logic signed [COORD_W-1:0] x_ext;
  logic signed [COORD_W-1:0] x_step;

  always_comb begin
    oc_d      = bus.ObstacleClock;
    prev_gs_d = game_state_e'(bus.gameState);
    active_d  = active_q;
    x_d       = x_q;
    type_d    = type_q;
    gap_cnt_d = gap_cnt_q;
    x_ext     = '0;
    x_step    = '0;

    if (enter_run) begin
      active_d  = '0;
      x_d[0]    = '0;
      x_d[1]    = '0;
      type_d[0] = '0;
      type_d[1] = '0;
      gap_cnt_d = GAP_INIT;
    end else if (run && tick) begin
      for (int i = 0; i < 2; i++) begin
        if (active_q[i]) begin
          x_ext  = {x_q[i][OBS_X_W-1], x_q[i]};
          x_step = x_ext - STEP_S;
          x_d[i] = x_step[OBS_X_W-1:0];
          if (x_step + obs_w(type_q[i]) <= 13'sd0) begin
            active_d[i] = 1'b0;
          end
        end
      end

      // Spawn looks at occupancy before this tick, so a slot that retires
      // now is only reused on a later tick. With both slots busy the counter
      // simply sits at zero until one frees up.
      if (gap_cnt_q != '0) begin
        gap_cnt_d = gap_cnt_q - 1'b1;
      end else if (!active_q[0]) begin
        active_d[0] = 1'b1;
        x_d[0]      = SPAWN_X;
        type_d[0]   = lfsr_q[1:0];
        gap_cnt_d   = GAP_INIT + {4'b0000, lfsr_q[5:2]};
      end else if (!active_q[1]) begin
        active_d[1] = 1'b1;
        x_d[1]      = SPAWN_X;
        type_d[1]   = lfsr_q[1:0];
        gap_cnt_d   = GAP_INIT + {4'b0000, lfsr_q[5:2]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc_q      <= 1'b0;
      prev_gs_q <= GS_IDLE;
      gap_cnt_q <= GAP_INIT;
      active_q  <= '0;
      x_q[0]    <= '0;
      x_q[1]    <= '0;
      type_q[0] <= '0;
      type_q[1] <= '0;
    end else begin
      oc_q      <= oc_d;
      prev_gs_q <= prev_gs_d;
      gap_cnt_q <= gap_cnt_d;
      active_q  <= active_d;
      x_q[0]    <= x_d[0];
      x_q[1]    <= x_d[1];
      type_q[0] <= type_d[0];
      type_q[1] <= type_d[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel mask
  // Scan coordinates of 4096 or more can never hit; otherwise the low 12 bits
  // are compared as non-negative 13-bit signed values against the sign-extended
  // slot box, so boxes hanging off the left edge clip naturally.
  // ---------------------------------------------------------------------------
  logic                      scan_ok;
  logic signed [COORD_W-1:0] scan_x, scan_y;
  logic signed [COORD_W-1:0] gx, gw, gh, gtop;
  logic [1:0]                hit;

  assign scan_ok = (bus.vgaX[31:12] == 20'd0) && (bus.vgaY[31:12] == 20'd0);
  assign scan_x  = {1'b0, bus.vgaX[11:0]};
  assign scan_y  = {1'b0, bus.vgaY[11:0]};

  always_comb begin
    hit  = '0;
    gx   = '0;
    gw   = '0;
    gh   = '0;
    gtop = '0;
    for (int i = 0; i < 2; i++) begin
      gx     = {x_q[i][OBS_X_W-1], x_q[i]};
      gw     = obs_w(type_q[i]);
      gh     = obs_h(type_q[i]);
      gtop   = GROUND_S - obs_top_off(type_q[i]);
      hit[i] = active_q[i] && scan_ok &&
               (gx <= scan_x) && (scan_x < gx + gw) &&
               (gtop <= scan_y) && (scan_y < gtop + gh);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.inGrey    = |hit;
  assign bus.obsActive = active_q;
  assign bus.obsX0     = x_q[0];
  assign bus.obsX1     = x_q[1];
  assign bus.obsType0  = type_q[0];
  assign bus.obsType1  = type_q[1];

endmodule
